seg_serial_ctrl: RTL and testbench

- Refresh sequencer for the graphic-mode 7-segment display on the serial shift-register board.
- On each request it snapshots the 32-bit segment image and steps the scan index 3→0 into the combinational segment mapper.
- It captures each returned 8-bit segment byte and shifts it out MSB-first on s_clk/s_data.
- After all 32 bits it pulses s_lat to latch the board's shift registers.

---
 rtl/seg_serial_ctrl.sv | 116 +++++++++++
 tb/tb_seg_serial_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_ctrl.sv
// Refresh sequencer for the serial shift-register 7-segment board: snapshots the image,
// walks the scan index through the external mapper and shifts each byte out MSB-first.
module seg_serial_ctrl #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned NUM_SCAN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] hexs_in,
    input  logic [7:0]  seg_byte,
    output logic [31:0] hexs_snap,
    output logic [2:0]  scan,
    output logic        s_clk,
    output logic        s_data,
    output logic        s_lat,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0] SCAN_TOP = 3'(NUM_SCAN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t             state;
    logic [6:0]         sr;        // remaining bits below the one currently on s_data
    logic [2:0]         bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               phase;     // 0: first half (s_clk low), 1: second half

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hexs_snap <= '0;
            scan      <= '0;
            s_clk     <= 1'b0;
            s_data    <= 1'b0;
            s_lat     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sr        <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            phase     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hexs_snap <= hexs_in;
                        scan      <= SCAN_TOP;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    sr      <= seg_byte[6:0];
                    s_data  <= seg_byte[7];
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            s_clk <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            s_clk   <= 1'b0;
                            sr      <= {sr[5:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                s_data <= 1'b0;
                                // scan 0 is the last byte, so the decrement never wraps
                                if (scan != 3'd0) begin
                                    scan  <= scan - 3'd1;
                                    state <= LOAD;
                                end else begin
                                    s_lat <= 1'b1;
                                    state <= LATCH;
                                end
                            end else begin
                                s_data <= sr[6];
                            end
                        end
                    end
                end
                LATCH: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            s_lat <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Bench for seg_serial_ctrl: frame-position model checked every cycle, plus directed frames
// with hand-computed streams, latencies and strobe counts (CLK_DIV=2 and CLK_DIV=1 builds).
module tb_seg_serial_ctrl;

    localparam int CD     = 2;
    localparam int NS     = 4;
    localparam int BYTE_C = 1 + 16 * CD;
    localparam int SH_END = NS * BYTE_C;
    localparam int LA_END = SH_END + 2 * CD;
    localparam int DONE_K = LA_END + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] hexs_in = '0;
    logic [7:0]  seg_byte;
    logic [31:0] hexs_snap;
    logic [2:0]  scan;
    logic        s_clk, s_data, s_lat, busy, done;

    logic        start1 = 1'b0;
    logic [31:0] hexs1 = '0;
    logic [7:0]  seg1;
    logic [31:0] snap1;
    logic [2:0]  scan1;
    logic        s_clk1, s_data1, s_lat1, busy1, done1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Stand-in mapper: byte of the image for that scan line, nibbles swapped on odd lines.
    function automatic logic [7:0] mapper(input logic [31:0] h, input logic [2:0] s);
        logic [7:0] b;
        if (s > 3'd3) return 8'h00;
        b = h[8*s +: 8];
        return s[0] ? {b[3:0], b[7:4]} : b;
    endfunction

    // Whole frame as seen on the wire, first bit sent in bit 31.
    function automatic logic [31:0] stream_of(input logic [31:0] h);
        logic [31:0] st = '0;
        for (int j = 0; j < NS; j++) st[31-8*j -: 8] = mapper(h, 3'(NS - 1 - j));
        return st;
    endfunction

    // Expected {hexs_snap, scan, s_clk, s_data, s_lat, busy, done} at frame position k.
    function automatic logic [39:0] model_out(input int k, input logic [31:0] sn);
        logic [31:0] st = stream_of(sn);
        logic [2:0]  sc = 3'd0;
        logic        ck = 1'b0, dt = 1'b0, lt = 1'b0, bz = 1'b0, dn = 1'b0;
        int j, off, b, ph;
        if (k >= 1 && k <= SH_END) begin
            j = (k - 1) / BYTE_C;
            off = (k - 1) % BYTE_C;
            sc = 3'(NS - 1 - j);
            bz = 1'b1;
            if (off != 0) begin
                b  = (off - 1) / (2 * CD);
                ph = (off - 1) % (2 * CD);
                ck = (ph >= CD);
                dt = st[31 - (8 * j + b)];
            end
        end else if (k > SH_END && k <= LA_END) begin
            lt = 1'b1;
            bz = 1'b1;
        end else if (k == DONE_K) begin
            dn = 1'b1;
        end
        return {sn, sc, ck, dt, lt, bz, dn};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    always_comb seg_byte = mapper(hexs_snap, scan);
    always_comb seg1 = mapper(snap1, scan1);

    seg_serial_ctrl #(.CLK_DIV(CD), .NUM_SCAN(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .hexs_in(hexs_in), .seg_byte(seg_byte),
        .hexs_snap(hexs_snap), .scan(scan), .s_clk(s_clk), .s_data(s_data), .s_lat(s_lat),
        .busy(busy), .done(done)
    );

    seg_serial_ctrl #(.CLK_DIV(1), .NUM_SCAN(NS)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .hexs_in(hexs1), .seg_byte(seg1),
        .hexs_snap(snap1), .scan(scan1), .s_clk(s_clk1), .s_data(s_data1), .s_lat(s_lat1),
        .busy(busy1), .done(done1)
    );

    // Frame position: 0 = idle, 1.. = cycles after the start-sampling edge.
    int          mk = 0;
    logic [31:0] msnap = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk    <= 0;
            msnap <= '0;
        end else if (mk == 0 || mk == DONE_K) begin
            if (start) begin
                mk    <= 1;
                msnap <= hexs_in;
            end else begin
                mk <= 0;
            end
        end else begin
            mk <= mk + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst)
            chk("cycle", {24'h0, hexs_snap, scan, s_clk, s_data, s_lat, busy, done},
                {24'h0, model_out(mk, msnap)});
    end

    // Board-side observers.
    logic [31:0] cap = '0, cap1 = '0;
    int rises = 0, rises_lat = 0, lat_cyc = 0, rises1 = 0, hi1 = 0;
    always @(posedge s_clk) begin
        cap = {cap[30:0], s_data};
        rises++;
        if (s_lat) rises_lat++;
    end
    always @(posedge s_clk1) begin
        cap1 = {cap1[30:0], s_data1};
        rises1++;
    end
    always @(negedge clk) begin
        if (s_lat) lat_cyc++;
        if (s_clk1) hi1++;
    end

    task automatic run_frame(input logic [31:0] h, input logic [31:0] want, input string tag);
        int n, r0, l0;
        @(posedge clk); #1;
        hexs_in = h;
        start = 1'b1;
        r0 = rises;
        l0 = lat_cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, DONE_K);
        chk({tag, " stream"}, cap, want);
        chk({tag, " sclk rises"}, rises - r0, 32);
        chk({tag, " lat cycles"}, lat_cyc - l0, 2 * CD);
    endtask

    initial begin
        int n, r0, h0, d0, d1, nd;

        chk("model map scan3", mapper(32'h8000_0000, 3'd3), 8'h08);
        chk("model stream 1", stream_of(32'h0000_0001), 32'h0000_0001);
        chk("model stream msb", stream_of(32'h8000_0000), 32'h0800_0000);

        #2;
        chk("reset outputs", {hexs_snap, scan, s_clk, s_data, s_lat, busy, done}, 40'h0);
        chk("reset outputs div1", {snap1, scan1, s_clk1, s_data1, s_lat1, busy1, done1}, 40'h0);
        #10 rst = 1'b0;

        // Abandon a frame mid-shift with an asynchronous reset.
        @(posedge clk); #1;
        hexs_in = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async reset", {hexs_snap, scan, s_clk, s_data, s_lat, busy, done}, 40'h0);
        #1 rst = 1'b0;

        run_frame(32'h0000_0001, 32'h0000_0001, "lsb");
        run_frame(32'h8000_0000, 32'h0800_0000, "msb");
        run_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones");
        chk("no sclk in latch", rises_lat, 0);

        // Start while busy and image change mid-frame are both ignored.
        @(posedge clk); #1;
        hexs_in = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (n == 50) start = 1'b1;
            if (n == 51) start = 1'b0;
            if (n == 60) hexs_in = 32'h0;
        end
        chk("busy-start latency", n, DONE_K);
        chk("busy-start stream", cap, 32'h2134_6578);
        repeat (3) @(posedge clk);
        #1 chk("busy-start no requeue", busy, 1'b0);

        // Start held high: back-to-back frames.
        @(posedge clk); #1;
        hexs_in = 32'h0F0F_0F0F;
        start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        nd = 0;
        d0 = 0;
        d1 = 0;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                if (nd == 0) d0 = n;
                if (nd == 1) d1 = n;
                nd++;
            end
        end
        start = 1'b0;
        chk("held done 1", d0, DONE_K);
        chk("held done 2", d1, 2 * DONE_K);
        n = 0;
        while ((busy || done) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held drains", busy, 1'b0);

        // CLK_DIV=1 build.
        @(posedge clk); #1;
        hexs1 = 32'hA5A5_0F0F;
        start1 = 1'b1;
        r0 = rises1;
        h0 = hi1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("div1 latency", n, 1 + NS * 17 + 2);
        chk("div1 stream", cap1, 32'h5AA5_F00F);
        chk("div1 sclk rises", rises1 - r0, 32);
        chk("div1 sclk high cycles", hi1 - h0, 32);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
